// File: rtl/rtr_pkg.sv
// Shared encodings and helpers for the RX token arbiter and the TX-side scheduler.
package rtr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } rtr_state_e;

  localparam int PKT_W = 55;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_next_port.sv
// Combinational rotating search: first enabled port strictly after tok (wraps to tok itself).
module rr_next_port
  import rtr_pkg::*;
#(
  parameter int N_PORTS = 4,
  localparam int IW = port_w(N_PORTS)
) (
  input  logic [IW-1:0]      tok,
  input  logic [N_PORTS-1:0] en,
  output logic [IW-1:0]      next,
  output logic               any_en
);

  always_comb begin
    logic [IW-1:0] cand;
    logic          found;
    next   = tok;
    any_en = |en;
    cand   = tok;
    found  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = (cand == IW'(N_PORTS - 1)) ? '0 : cand + 1'b1;
      if (!found && en[cand]) begin
        found = 1'b1;
        next  = cand;
      end
    end
  end

endmodule

// File: rtl/rx_token_arbiter.sv
// Round-robin token poller feeding one registered output slot from N_PORTS receivers.
// Optional RX_ARB_PORT_MASK_EN adds a port_en mask that gates which ports are polled.
module rx_token_arbiter
  import rtr_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = PKT_W,
  parameter int DWELL   = 8,
  localparam int IW     = port_w(N_PORTS)
) (
  input  logic                      Clk_S,
  input  logic                      Rst_n,
  input  logic [N_PORTS-1:0]        rx_valid,
  input  logic [N_PORTS*DATA_W-1:0] rx_data,
  output logic [N_PORTS-1:0]        rx_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IW-1:0]             out_port,
  input  logic                      out_ready
`ifdef RX_ARB_PORT_MASK_EN
  ,
  input  logic [N_PORTS-1:0]        port_en
`endif
);

  localparam int DW_W = $clog2(DWELL);

  rtr_state_e                      state;
  logic [IW-1:0]                   tok;
  logic [DW_W-1:0]                 dwell;
  logic [N_PORTS-1:0]              en;
  logic [N_PORTS-1:0][DATA_W-1:0]  port_data;
  logic [IW-1:0]                   tok_nxt;
  logic [IW-1:0]                   gnt_port;
  logic                            any_en;
  logic                            sink_free;

`ifdef RX_ARB_PORT_MASK_EN
  assign en = port_en;
`else
  assign en = '1;
`endif

  assign port_data = rx_data;
  // A disabled token holder hands over to the next enabled port before granting.
  assign gnt_port  = en[tok] ? tok : tok_nxt;
  assign sink_free = !out_valid || out_ready;

  rr_next_port #(.N_PORTS(N_PORTS)) u_next (
    .tok    (tok),
    .en     (en),
    .next   (tok_nxt),
    .any_en (any_en)
  );

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      tok       <= '0;
      dwell     <= '0;
      rx_ready  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sink_free && any_en) begin
            state              <= GRANT;
            tok                <= gnt_port;
            dwell              <= '0;
            rx_ready           <= '0;
            rx_ready[gnt_port] <= 1'b1;
          end
        end
        GRANT: begin
          if (rx_valid[tok]) begin
            out_valid <= 1'b1;
            out_data  <= port_data[tok];
            out_port  <= tok;
            rx_ready  <= '0;
            state     <= RELEASE;
          end else if (!en[tok] || dwell == DW_W'(DWELL - 1)) begin
            tok      <= tok_nxt;
            rx_ready <= '0;
            state    <= IDLE;
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        RELEASE: begin
          // Receiver drops valid one cycle after seeing ready fall.
          if (!rx_valid[tok]) begin
            tok   <= tok_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_token_arbiter.sv
// Bench for rx_token_arbiter: receiver models, delivery scoreboard, vector table plus corner sequences.
module tb_rx_token_arbiter;

  localparam int N     = 4;
  localparam int W     = 55;
  localparam int DWELL = 8;

  logic           Clk_S = 1'b0;
  logic           Rst_n;
  logic [N-1:0]   rx_valid;
  logic [N*W-1:0] rx_data;
  logic [N-1:0]   rx_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_port;
  logic           out_ready;
  logic [N-1:0]   port_en;

  always #5 Clk_S = ~Clk_S;

  rx_token_arbiter #(.N_PORTS(N), .DATA_W(W), .DWELL(DWELL)) dut (
    .Clk_S     (Clk_S),
    .Rst_n     (Rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_ready (out_ready)
`ifdef RX_ARB_PORT_MASK_EN
    ,
    .port_en   (port_en)
`endif
  );

  typedef struct { logic [1:0] port; logic [W-1:0] data; } pkt_t;
  typedef struct { logic [N-1:0] pend; int n; int ports[4]; } vec_t;

  pkt_t         sb[$];
  int           delivered[$];
  int           grants[$];
  int           runs[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc, cur_len, ov_rise_cyc;
  int           rdy_rise_cyc[N];
  logic [N-1:0] has_pkt, prev_rdy;
  logic         prev_ov;
  logic [W-1:0] pkt[N];
  vec_t         vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    int r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: observe at negedge, then update registered receiver models after posedge.
  task automatic step();
    logic [N-1:0] rdy;
    @(negedge Clk_S);
    rdy = rx_ready;
    chk("onehot", ($countones(rx_ready) <= 1), 1);
    if (prev_rdy != 0 && rx_ready != prev_rdy) runs.push_back(cur_len);
    if (rx_ready != 0 && rx_ready != prev_rdy) begin
      grants.push_back(idx_of(rx_ready));
      rdy_rise_cyc[idx_of(rx_ready)] = cyc;
      cur_len = 1;
    end else if (rx_ready != 0) begin
      cur_len++;
    end
    prev_rdy = rx_ready;
    if (out_valid && !prev_ov) ov_rise_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      delivered.push_back(int'(out_port));
      if (sb.size() == 0) chk("pop_on_empty", 1, 0);
      else begin
        pkt_t e;
        e = sb.pop_front();
        chk("out_port", out_port, e.port);
        chk("out_data", out_data, e.data);
      end
    end
    @(posedge Clk_S);
    #1;
    for (int p = 0; p < N; p++) begin
      if (rdy[p] && has_pkt[p]) begin
        if (!rx_valid[p]) sb.push_back('{port: 2'(p), data: pkt[p]});
        rx_valid[p] = 1'b1;
      end else if (rx_valid[p]) begin
        rx_valid[p] = 1'b0;
        has_pkt[p]  = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    Rst_n     = 1'b0;
    rx_valid  = '0;
    has_pkt   = '0;
    out_ready = 1'b1;
    port_en   = '1;
    prev_rdy  = '0;
    prev_ov   = 1'b0;
    cur_len   = 0;
    ov_rise_cyc = -1;
    sb.delete(); delivered.delete(); grants.delete(); runs.delete();
    repeat (2) @(posedge Clk_S);
    #2 Rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic load(input logic [N-1:0] mask);
    for (int p = 0; p < N; p++) begin
      has_pkt[p] = mask[p];
      pkt[p]     = W'({$urandom(), $urandom()});
      rx_data[p*W +: W] = pkt[p];
    end
  endtask

  task automatic wait_delivered(input int n, input int budget, input string name);
    int c = 0;
    while (delivered.size() < n && c < budget) begin step(); c++; end
    if (delivered.size() < n) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    logic [W-1:0] held;
    rx_data = '0;
    vecs[0].pend = 4'b0100; vecs[0].n = 1; vecs[0].ports = '{2, 0, 0, 0};
    vecs[1].pend = 4'b1111; vecs[1].n = 4; vecs[1].ports = '{0, 1, 2, 3};
    vecs[2].pend = 4'b1010; vecs[2].n = 2; vecs[2].ports = '{1, 3, 0, 0};
    vecs[3].pend = 4'b1001; vecs[3].n = 2; vecs[3].ports = '{0, 3, 0, 0};
    vecs[4].pend = 4'b0000; vecs[4].n = 0; vecs[4].ports = '{0, 0, 0, 0};

    do_reset();
    #1;
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_port", out_port, 0);

    // Vector table: pending mask -> delivery order
    for (int v = 0; v < 5; v++) begin
      do_reset();
      load(vecs[v].pend);
      for (int c = 0; c < 150 && delivered.size() < vecs[v].n; c++) step();
      repeat (10) step();
      chk($sformatf("vec%0d_count", v), delivered.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < delivered.size(); i++)
        chk($sformatf("vec%0d_port%0d", v, i), delivered[i], vecs[v].ports[i]);
      chk($sformatf("vec%0d_sb_empty", v), sb.size(), 0);
    end

    // Port 2 waiting: polls 0,1 first, 2-cycle latency, then moves to port 3
    do_reset();
    load(4'b0100);
    wait_delivered(1, 100, "t1");
    repeat (DWELL + 5) step();
    if (grants.size() < 4) chk("t1_grant_count", grants.size(), 4);
    else for (int i = 0; i < 4; i++) chk($sformatf("t1_grant%0d", i), grants[i], i);
    chk("t1_latency", ov_rise_cyc - rdy_rise_cyc[2], 2);

    // Idle ports: each bit high DWELL cycles, order 0,1,2,3,0
    do_reset();
    repeat (5 * (DWELL + 1) + 2) step();
    if (grants.size() < 5 || runs.size() < 4) chk("t2_sizes", 0, 1);
    else begin
      for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), grants[i], i % N);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_dwell%0d", i), runs[i], DWELL);
    end

    // Sink stall holds the packet and blocks granting
    do_reset();
    out_ready = 1'b0;
    load(4'b0011);
    for (int c = 0; c < 50 && !out_valid; c++) step();
    chk("t3_captured", out_valid, 1);
    chk("t3_port", out_port, 0);
    chk("t3_data", out_data, pkt[0]);
    held = out_data;
    repeat (4) step();
    bad = 0;
    repeat (20) begin
      step();
      if (rx_ready != 0 || out_data !== held || !out_valid) bad++;
    end
    chk("t3_stall_hold", bad, 0);
    out_ready = 1'b1;
    wait_delivered(2, 100, "t3");
    if (delivered.size() >= 2) chk("t3_next_port", delivered[1], 1);
    chk("t3_sb_empty", sb.size(), 0);

    // Async reset during GRANT, polling restarts at port 0
    do_reset();
    load(4'b0010);
    for (int c = 0; c < 50 && rx_ready != 4'b0010; c++) step();
    chk("t5_in_grant", rx_ready, 4'b0010);
    step();
    #2 Rst_n = 1'b0;
    #1;
    chk("t5_rst_rx_ready", rx_ready, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    do_reset();
    repeat (3) step();
    if (grants.size() < 1) chk("t5_regrant", 0, 1);
    else chk("t5_restart_port", grants[0], 0);

`ifdef RX_ARB_PORT_MASK_EN
    // Masked polling: only ports 1 and 3, then nothing at all
    do_reset();
    port_en = 4'b1010;
    repeat (4 * (DWELL + 1) + 4) step();
    if (grants.size() < 4) chk("t6_grant_count", grants.size(), 4);
    else for (int i = 0; i < 4; i++) chk($sformatf("t6_grant%0d", i), grants[i], (i % 2) ? 3 : 1);
    port_en = 4'b0000;
    repeat (3) step();
    bad = 0;
    repeat (20) begin
      step();
      if (rx_ready != 0) bad++;
    end
    chk("t6_no_enable", bad, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
